// File: rtl/rvlab_uart_rx.sv
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling FSM and a small receive FIFO.
// States: IDLE | line idle, waiting for a low level
//         START | counting to mid start bit, rejects glitches
//         DATA | sampling 8 data bits LSB first
//         STOP | sampling stop bit, push or flag framing error
//         BREAK | line stuck low after framing error, wait for high
module rvlab_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       err_clr_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_sync1, r_rx_s;
    logic          w_push, w_frame_err, w_cnt_zero;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic          r_overflow;
    logic          w_empty, w_full, w_pop, w_wr, w_ovf;

    // Synchronizer resets to idle-high so a line held low at release reads as a start edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = CNT_FULL;
                        w_idx_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt[r_idx] = r_rx_s;
                    w_cnt_nxt          = CNT_FULL;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (r_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Extra pointer MSB separates full from empty; a pop frees the slot a full push lands in.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && ready_i;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovf   = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (err_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign valid_o     = !w_empty;
    assign data_o      = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
    assign frame_err_o = w_frame_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_rvlab_uart_rx.sv
// Self-checking bench for rvlab_uart_rx: vector table, corner-case sequences and random bytes vs a queue model.
module tb_rvlab_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       ready   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovf;

    rvlab_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overflow_o  (ovf),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_mem [0:1023];
    int         got_n        = 0;
    int         valid_cycles = 0;
    int         ferr_cnt     = 0;
    int         hold_viol    = 0;
    logic       prev_hold    = 1'b0;
    logic [7:0] prev_data    = 8'h00;
    bit         rand_ready   = 1'b0;
    int         rd           = 0;

    // Consumer-side observer, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                got_mem[got_n[9:0]] <= data;
                got_n <= got_n + 1;
            end
            if (valid) valid_cycles <= valid_cycles + 1;
            if (ferr) ferr_cnt <= ferr_cnt + 1;
            if (prev_hold && valid && data != prev_data) hold_viol <= hold_viol + 1;
            prev_hold <= valid && !ready;
            prev_data <= data;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        checks++;
        if (rd >= got_n) begin
            errors++;
            $display("FAIL %s: got no byte expected %0h", name, exp);
        end else begin
            if (got_mem[rd[9:0]] !== exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, got_mem[rd[9:0]], exp);
            end
            rd++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic lvl);
        rx = lvl;
        ticks(CPB);
    endtask

    task automatic send_body(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        send_body(b, stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    logic [7:0] fill_a [5];
    logic [7:0] fill_b [4];
    int v0, f0, n0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h33, 1'b0, 0, 1};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        fill_a  = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
        fill_b  = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b0;
        ticks(3);
        check("reset valid", 32'(valid), 0);
        check("reset data", 32'(data), 0);
        check("reset ferr", 32'(ferr), 0);
        check("reset ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        ticks(4);

        // Single frames with the consumer always ready.
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cycles; f0 = ferr_cnt; n0 = got_n; rd = got_n;
            send_frame(vecs[i].data, vecs[i].stop);
            ticks(6);
            check($sformatf("vec%0d valid cycles", i), 32'(valid_cycles - v0), 32'(vecs[i].exp_bytes));
            check($sformatf("vec%0d ferr pulses", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d pops", i), 32'(got_n - n0), 32'(vecs[i].exp_bytes));
            if (vecs[i].exp_bytes > 0) expect_byte($sformatf("vec%0d data", i), vecs[i].data);
        end

        // Short low glitch must be rejected, following frame still received.
        v0 = valid_cycles; f0 = ferr_cnt; rd = got_n;
        rx = 1'b0;
        ticks(2);
        rx = 1'b1;
        ticks(30);
        check("glitch valid", 32'(valid_cycles - v0), 0);
        check("glitch ferr", 32'(ferr_cnt - f0), 0);
        send_frame(8'h7E, 1'b1);
        ticks(6);
        expect_byte("after glitch", 8'h7E);

        // Overflow with consumer stalled.
        ready = 1'b0;
        rd = got_n; n0 = got_n;
        for (int i = 0; i < 5; i++) begin
            send_frame(fill_a[i], 1'b1);
            ticks(3);
        end
        ticks(4);
        check("ovf set", 32'(ovf), 1);
        check("full valid", 32'(valid), 1);
        check("full head", 32'(data), 32'h00);
        check("stalled pops", 32'(got_n - n0), 0);
        ready = 1'b1;
        ticks(8);
        for (int i = 0; i < 4; i++) expect_byte($sformatf("drain%0d", i), fill_a[i]);
        check("drain pops", 32'(got_n - n0), 4);
        check("drained valid", 32'(valid), 0);
        check("ovf sticky", 32'(ovf), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf cleared", 32'(ovf), 0);

        // Bad stop bit followed by a long break.
        f0 = ferr_cnt; n0 = got_n; rd = got_n;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)));
        rx = 1'b0;
        ticks(CPB + 40);
        rx = 1'b1;
        ticks(10);
        check("break ferr", 32'(ferr_cnt - f0), 1);
        check("break pops", 32'(got_n - n0), 0);
        send_frame(8'h12, 1'b1);
        ticks(6);
        expect_byte("after break", 8'h12);
        check("break ferr final", 32'(ferr_cnt - f0), 1);

        // Full FIFO, fifth byte completes on the same cycle as a pop.
        ready = 1'b0;
        rd = got_n; n0 = got_n;
        for (int i = 0; i < 4; i++) begin
            send_frame(fill_b[i], 1'b1);
            ticks(3);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'(8'hC3 >> i));
        rx = 1'b1;
        ticks(CPB - 2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        ticks(3);
        check("pop+push ovf", 32'(ovf), 0);
        ready = 1'b1;
        ticks(8);
        for (int i = 0; i < 4; i++) expect_byte($sformatf("pp%0d", i), fill_b[i]);
        expect_byte("pp last", 8'hC3);
        check("pp empty", 32'(valid), 0);
        check("pp ovf final", 32'(ovf), 0);

        // Reset mid-frame.
        rd = got_n; n0 = got_n;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
        rst_n = 1'b0;
        rx = 1'b1;
        ticks(3);
        check("midrst valid", 32'(valid), 0);
        check("midrst data", 32'(data), 0);
        check("midrst ferr", 32'(ferr), 0);
        check("midrst ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        ticks(60);
        check("midrst pops", 32'(got_n - n0), 0);
        send_frame(8'h9A, 1'b1);
        ticks(6);
        expect_byte("after midrst", 8'h9A);

        // Reset released while the line is already low: start bit still seen.
        rd = got_n;
        rst_n = 1'b0;
        rx = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        drive_bit(1'b0);
        send_body(8'h5A, 1'b1);
        ticks(6);
        expect_byte("low at release", 8'h5A);

        // Random bytes with a randomly stalling consumer, checked against a byte queue.
        rd = got_n; n0 = got_n;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            ticks($urandom_range(1, 6));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        ticks(10);
        check("rand pops", 32'(got_n - n0), 32'(exp_q.size()));
        foreach (exp_q[i]) expect_byte($sformatf("rand%0d", i), exp_q[i]);
        check("rand ovf", 32'(ovf), 0);

        check("total ferr", 32'(ferr_cnt), 2);
        check("data hold stable", 32'(hold_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvlab_uart_rx.md
RVLAB_UART_RX -- requirements
Module: rvlab_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk_i cycles per UART bit (115200 baud at 100 MHz); legal values are 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO depth; it is a power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rx_i, input, 1 bit: asynchronous serial line in 8N1 format; idle level is 1.
REQ-006 SHALL have port data_o, output, 8 bits: the received byte at the FIFO head.
REQ-007 SHALL have port valid_o, output, 1 bit: the FIFO is not empty and data_o is valid.
REQ-008 SHALL have port ready_i, input, 1 bit: the consumer accepts data_o.
REQ-009 SHALL have port frame_err_o, output, 1 bit: a one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overflow_o, output, 1 bit: sticky flag set when a received byte is dropped because the FIFO is full.
REQ-011 SHALL have port err_clr_i, input, 1 bit: clears overflow_o.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer initialised to 1; the FSM uses only the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and BREAK, plus a bit counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-014 In IDLE, on rx_s==0, SHALL go to START and load the counter with CLKS_PER_BIT/2 - 1 (integer division).
REQ-015 In START, on counter==0, SHALL sample rx_s: if 1, treat it as a glitch and return to IDLE with no output; if 0, go to DATA with the counter at CLKS_PER_BIT-1 and the index at 0; otherwise the counter decrements.
REQ-016 In DATA, on each counter==0, SHALL sample rx_s into shift-register bit [index] (LSB first) and reload the counter; after index 7 it goes to STOP.
REQ-017 In STOP, on counter==0, SHALL sample rx_s: if 1, push the byte and go to IDLE; if 0, assert frame_err_o for exactly that cycle, discard the byte and go to BREAK.
REQ-018 BREAK SHALL remain until rx_s==1 and then go to IDLE, so a held-low line yields exactly one frame_err_o pulse.
REQ-019 Latency: valid_o SHALL rise on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-020 The FIFO SHALL be first-in first-out: valid_o = !empty; data_o = head entry; a pop occurs when valid_o && ready_i.
REQ-021 data_o SHALL hold stable while valid_o && !ready_i.
REQ-022 A push when full with no pop in the same cycle SHALL drop the new byte, keep the FIFO contents, and set overflow_o.
REQ-023 A push and a pop in the same cycle SHALL both take effect in all fill states, including full; occupancy is unchanged and overflow_o is not set.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit or an occupancy counter.
REQ-025 err_clr_i SHALL clear overflow_o on the next edge; if err_clr_i and an overflow event coincide, overflow_o SHALL be 1 (set wins).
REQ-026 ready_i SHALL be ignored while valid_o==0.

Reset
REQ-027 While rst_ni==0 at a clock edge, the block SHALL: set the FSM to IDLE; clear counters, shift register, FIFO pointers and occupancy; set both synchronizer flops to 1; and drive valid_o=0, frame_err_o=0, overflow_o=0 and data_o=8'h00 on the following cycle.
REQ-028 A reset asserted mid-frame SHALL abandon the frame; after release, the remaining bits of that frame SHALL NOT produce a byte unless a new 1->0 transition is seen in IDLE.
REQ-029 If reset is released while rx_i is low, the block SHALL detect a start bit after 2 synchronizer cycles, because the synchronizer resets to 1.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-030 Bench SHALL send 8'hA5 with ready_i=1 -> exactly one valid_o cycle with data_o=8'hA5; frame_err_o=0.
REQ-031 Bench SHALL send 8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81 with ready_i=0 -> FIFO holds 00,FF,55,3C; overflow_o=1; raising ready_i yields those four bytes in order, then valid_o=0.
REQ-032 Bench SHALL apply a 2-cycle low glitch on rx_i -> no valid_o and no frame_err_o; a following 8'h7E is received correctly.
REQ-033 Bench SHALL send a frame with stop bit 0, then hold rx low for 40 cycles, then send 8'h12 -> exactly one frame_err_o pulse, then data_o=8'h12.
REQ-034 Bench SHALL fill the FIFO and complete a 5th byte 8'hC3 on the same cycle as a pop -> overflow_o stays 0 and 8'hC3 is the last byte read.
REQ-035 Bench SHALL assert reset after data bit 3 of a frame -> no valid_o, outputs at reset values, and the next full frame 8'h9A is received correctly.
